// File: rtl/tone_synth_pkg.sv
// Shared constants and state type for the tone synthesiser.
// Optional feature macro: TONE_SYNTH_OCTAVE_EN (octave_up input on tone_synth).
package tone_synth_pkg;

    localparam int unsigned HalfW = 18;

    // Half-period of each note in 100 MHz clock cycles
    localparam logic [HalfW-1:0] HalfC4 = 18'd191113;
    localparam logic [HalfW-1:0] HalfD4 = 18'd170265;
    localparam logic [HalfW-1:0] HalfE4 = 18'd151686;
    localparam logic [HalfW-1:0] HalfF4 = 18'd143174;
    localparam logic [HalfW-1:0] HalfG4 = 18'd127551;
    localparam logic [HalfW-1:0] HalfA4 = 18'd113636;
    localparam logic [HalfW-1:0] HalfB4 = 18'd101239;
    localparam logic [HalfW-1:0] HalfC5 = 18'd95557;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StGap  = 2'd2
    } state_e;

endpackage

// File: rtl/tone_period_rom.sv
// One-hot note byte to half-period lookup; lowest set bit wins, rest (0) gives 0.
// Unaffected by TONE_SYNTH_OCTAVE_EN; octave shifting happens in tone_synth.
module tone_period_rom
    import tone_synth_pkg::*;
(
    input  logic [7:0]       note_i,
    output logic [HalfW-1:0] half_period_o
);

    always_comb begin
        half_period_o = '0;
        if      (note_i[0]) half_period_o = HalfC4;
        else if (note_i[1]) half_period_o = HalfD4;
        else if (note_i[2]) half_period_o = HalfE4;
        else if (note_i[3]) half_period_o = HalfF4;
        else if (note_i[4]) half_period_o = HalfG4;
        else if (note_i[5]) half_period_o = HalfA4;
        else if (note_i[6]) half_period_o = HalfB4;
        else if (note_i[7]) half_period_o = HalfC5;
    end

endmodule

// File: rtl/tone_synth.sv
// Plays one note per accept: square wave for DUR_CYCLES, silent gap for GAP_CYCLES.
// Define TONE_SYNTH_OCTAVE_EN to add the octave_up input (halves every half-period).
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int unsigned DUR_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       read,
    input  logic       note_valid,
    input  logic [7:0] note_in,
`ifdef TONE_SYNTH_OCTAVE_EN
    input  logic       octave_up,
`endif
    output logic       note_ready,
    output logic       audio_out,
    output logic       busy,
    output logic       note_done
);

    localparam int unsigned DurW = $clog2(DUR_CYCLES + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam logic [DurW-1:0] DurLast = DurW'(DUR_CYCLES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       note_q, note_d;
    logic [DurW-1:0]  dur_q, dur_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [HalfW-1:0] half_cnt_q, half_cnt_d;
    logic             audio_q, audio_d;
    logic             done_q, done_d;

    logic [HalfW-1:0] rom_half;
    logic [HalfW-1:0] half_period;
    logic [HalfW-1:0] half_last;

    tone_period_rom u_rom (
        .note_i        (note_q),
        .half_period_o (rom_half)
    );

`ifdef TONE_SYNTH_OCTAVE_EN
    logic oct_q, oct_d;
    assign half_period = oct_q ? (rom_half >> 1) : rom_half;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) oct_q <= 1'b0;
        else       oct_q <= oct_d;
    end
`else
    assign half_period = rom_half;
`endif

    assign half_last  = half_period - HalfW'(1);
    assign note_ready = (state_q == StIdle) && read;
    assign busy       = (state_q != StIdle);
    assign audio_out  = audio_q;
    assign note_done  = done_q;

    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        dur_d      = dur_q;
        gap_d      = gap_q;
        half_cnt_d = half_cnt_q;
        audio_d    = audio_q;
        done_d     = 1'b0;
`ifdef TONE_SYNTH_OCTAVE_EN
        oct_d      = oct_q;
`endif
        case (state_q)
            StIdle: begin
                if (note_valid && read) begin
                    state_d    = StPlay;
                    note_d     = note_in;
                    dur_d      = '0;
                    half_cnt_d = '0;
                    audio_d    = 1'b0;
`ifdef TONE_SYNTH_OCTAVE_EN
                    oct_d      = octave_up;
`endif
                end
            end
            StPlay: begin
                if (!read) begin
                    state_d = StIdle;
                    audio_d = 1'b0;
                end else if (dur_q == DurLast) begin
                    state_d = StGap;
                    gap_d   = '0;
                    audio_d = 1'b0;
                end else begin
                    dur_d = dur_q + DurW'(1);
                    // A rest has a zero half-period and never toggles
                    if (half_period != '0) begin
                        if (half_cnt_q == half_last) begin
                            half_cnt_d = '0;
                            audio_d    = ~audio_q;
                        end else begin
                            half_cnt_d = half_cnt_q + HalfW'(1);
                        end
                    end
                end
            end
            StGap: begin
                if (!read) begin
                    state_d = StIdle;
                end else if (gap_q == GapLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                audio_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            note_q     <= '0;
            dur_q      <= '0;
            gap_q      <= '0;
            half_cnt_q <= '0;
            audio_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            gap_q      <= gap_d;
            half_cnt_q <= half_cnt_d;
            audio_q    <= audio_d;
            done_q     <= done_d;
        end
    end

endmodule
